// File: rtl/mem_req_queue.sv
// Circular request queue between a cache and memory. Pending write-backs
// can be searched by line address so that reads can forward dirty data.
module mem_req_queue #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 3,
  parameter int unsigned s_mask   = 2**s_offset,
  parameter int unsigned s_line   = 8*s_mask,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_write,
  input  logic [31:0]             in_address,
  input  logic [s_line-1:0]       in_wdata,
  input  logic [s_mask-1:0]       in_byte_enable,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_write,
  output logic [31:0]             out_address,
  output logic [s_line-1:0]       out_wdata,
  output logic [s_mask-1:0]       out_byte_enable,
  output logic [$clog2(DEPTH):0]  count,
  input  logic [31:0]             lookup_address,
  output logic                    lookup_hit,
  output logic [s_line-1:0]       lookup_wdata,
  output logic [s_mask-1:0]       lookup_byte_enable
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              write;
    logic [31:0]       address;
    logic [s_line-1:0] wdata;
    logic [s_mask-1:0] byte_enable;
  } entry_t;

  // Reject parameter sets that break pointer wrap or the address split.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || (s_index + s_offset) > 32) begin : g_bad_params
    $error("mem_req_queue: illegal DEPTH/s_index/s_offset combination");
  end

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   scan_idx;
  logic               enq;
  logic               deq;
  logic               lookup_unused;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  assign out_write       = mem[head].write;
  assign out_address     = mem[head].address;
  assign out_wdata       = mem[head].wdata;
  assign out_byte_enable = mem[head].byte_enable;

  // Byte-offset bits never take part in the line match.
  assign lookup_unused = ^lookup_address[s_offset-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (enq) begin
        mem[tail] <= '{write: in_write, address: in_address,
                       wdata: in_wdata, byte_enable: in_byte_enable};
        tail      <= tail + PTR_W'(1);
      end
      if (deq) begin
        head <= head + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to youngest so the youngest matching write wins.
  always_comb begin
    lookup_hit         = 1'b0;
    lookup_wdata       = '0;
    lookup_byte_enable = '0;
    scan_idx           = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && mem[scan_idx].write &&
          (mem[scan_idx].address[31:s_offset] == lookup_address[31:s_offset])) begin
        lookup_hit         = 1'b1;
        lookup_wdata       = mem[scan_idx].wdata;
        lookup_byte_enable = mem[scan_idx].byte_enable;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: a vector table for fill/drain/full/empty
// behaviour, then hand-written wrap, lookup, backpressure and reset sequences.
module tb_mem_req_queue;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_write;
  logic [31:0]   in_address;
  logic [255:0]  in_wdata;
  logic [31:0]   in_byte_enable;
  logic          out_valid;
  logic          out_ready;
  logic          out_write;
  logic [31:0]   out_address;
  logic [255:0]  out_wdata;
  logic [31:0]   out_byte_enable;
  logic [2:0]    count;
  logic [31:0]   lookup_address;
  logic          lookup_hit;
  logic [255:0]  lookup_wdata;
  logic [31:0]   lookup_byte_enable;

  int n_tests = 0;
  int n_fail  = 0;

  mem_req_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_write(in_write),
    .in_address(in_address), .in_wdata(in_wdata), .in_byte_enable(in_byte_enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_write(out_write),
    .out_address(out_address), .out_wdata(out_wdata), .out_byte_enable(out_byte_enable),
    .count(count),
    .lookup_address(lookup_address), .lookup_hit(lookup_hit),
    .lookup_wdata(lookup_wdata), .lookup_byte_enable(lookup_byte_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        iw;
    logic [31:0] ia;
    logic [31:0] iseed;
    logic        ordy;
    logic [31:0] la;
    logic [2:0]  ecnt;
    logic        eov;
    logic        eir;
    logic [31:0] eoaddr;
    logic [31:0] eoseed;
    logic        eow;
    logic        ehit;
    logic [31:0] elseed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic iw, input logic [31:0] ia,
                              input logic [31:0] iseed, input logic ordy, input logic [31:0] la,
                              input logic [2:0] ecnt, input logic eov, input logic eir,
                              input logic [31:0] eoaddr, input logic [31:0] eoseed,
                              input logic eow, input logic ehit, input logic [31:0] elseed);
    vec_t v;
    v.iv = iv; v.iw = iw; v.ia = ia; v.iseed = iseed; v.ordy = ordy; v.la = la;
    v.ecnt = ecnt; v.eov = eov; v.eir = eir; v.eoaddr = eoaddr; v.eoseed = eoseed;
    v.eow = eow; v.ehit = ehit; v.elseed = elseed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, then sample just after the edge.
  task automatic cyc(input logic iv, input logic iw, input logic [31:0] ia,
                     input logic [31:0] seed, input logic ordy, input logic [31:0] la);
    @(negedge clk);
    in_valid       = iv;
    in_write       = iw;
    in_address     = ia;
    in_wdata       = {8{seed}};
    in_byte_enable = seed;
    out_ready      = ordy;
    lookup_address = la;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [31:0] sb[$];
  logic [31:0] a;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_write = 1'b0; in_address = '0; in_wdata = '0;
    in_byte_enable = '0; out_ready = 1'b0; lookup_address = '0;

    // iv iw addr seed ordy lookup | cnt ov ir oaddr oseed ow hit lseed
    vecs.push_back(mk(1'b1,1'b1,32'h100,32'hA1A1_0001,1'b0,32'h11F, 3'd1,1'b1,1'b1,32'h100,32'hA1A1_0001,1'b1,1'b1,32'hA1A1_0001));
    vecs.push_back(mk(1'b1,1'b1,32'h120,32'hA2A2_0002,1'b0,32'h13F, 3'd2,1'b1,1'b1,32'h100,32'hA1A1_0001,1'b1,1'b1,32'hA2A2_0002));
    vecs.push_back(mk(1'b1,1'b1,32'h140,32'hA3A3_0003,1'b0,32'h13F, 3'd3,1'b1,1'b1,32'h100,32'hA1A1_0001,1'b1,1'b1,32'hA2A2_0002));
    vecs.push_back(mk(1'b1,1'b1,32'h160,32'hA4A4_0004,1'b0,32'h160, 3'd4,1'b1,1'b0,32'h100,32'hA1A1_0001,1'b1,1'b1,32'hA4A4_0004));
    vecs.push_back(mk(1'b1,1'b1,32'h180,32'hEEEE_EEEE,1'b0,32'h180, 3'd4,1'b1,1'b0,32'h100,32'hA1A1_0001,1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b1,1'b1,32'h180,32'hA5A5_0005,1'b1,32'h180, 3'd3,1'b1,1'b1,32'h120,32'hA2A2_0002,1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b1,1'b1,32'h1A0,32'hA6A6_0006,1'b1,32'h1A0, 3'd3,1'b1,1'b1,32'h140,32'hA3A3_0003,1'b1,1'b1,32'hA6A6_0006));
    vecs.push_back(mk(1'b0,1'b0,32'h0,  32'h0,        1'b1,32'h120, 3'd2,1'b1,1'b1,32'h160,32'hA4A4_0004,1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b0,1'b0,32'h0,  32'h0,        1'b1,32'h160, 3'd1,1'b1,1'b1,32'h1A0,32'hA6A6_0006,1'b1,1'b0,32'h0));
    vecs.push_back(mk(1'b0,1'b0,32'h0,  32'h0,        1'b1,32'h1A0, 3'd0,1'b0,1'b1,32'h0,  32'h0,        1'b0,1'b0,32'h0));
    vecs.push_back(mk(1'b0,1'b0,32'h0,  32'h0,        1'b1,32'h1A0, 3'd0,1'b0,1'b1,32'h0,  32'h0,        1'b0,1'b0,32'h0));
    vecs.push_back(mk(1'b1,1'b0,32'h200,32'hB0B0_0000,1'b0,32'h200, 3'd1,1'b1,1'b1,32'h200,32'hB0B0_0000,1'b0,1'b0,32'h0));

    // Reset values while rst is held low
    @(negedge clk); @(negedge clk);
    chk("rst count", 256'(count), 256'(0));
    chk("rst out_valid", 256'(out_valid), 256'(0));
    chk("rst in_ready", 256'(in_ready), 256'(1));
    chk("rst lookup_hit", 256'(lookup_hit), 256'(0));
    chk("rst out_address", 256'(out_address), 256'(0));
    chk("rst out_wdata", out_wdata, 256'(0));
    rst = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].iv, vecs[i].iw, vecs[i].ia, vecs[i].iseed, vecs[i].ordy, vecs[i].la);
      chk($sformatf("v%0d count", i), 256'(count), 256'(vecs[i].ecnt));
      chk($sformatf("v%0d out_valid", i), 256'(out_valid), 256'(vecs[i].eov));
      chk($sformatf("v%0d in_ready", i), 256'(in_ready), 256'(vecs[i].eir));
      chk($sformatf("v%0d lookup_hit", i), 256'(lookup_hit), 256'(vecs[i].ehit));
      chk($sformatf("v%0d lookup_wdata", i), lookup_wdata,
          vecs[i].ehit ? {8{vecs[i].elseed}} : 256'(0));
      chk($sformatf("v%0d lookup_be", i), 256'(lookup_byte_enable),
          256'(vecs[i].ehit ? vecs[i].elseed : 32'h0));
      if (vecs[i].eov) begin
        chk($sformatf("v%0d out_address", i), 256'(out_address), 256'(vecs[i].eoaddr));
        chk($sformatf("v%0d out_wdata", i), out_wdata, {8{vecs[i].eoseed}});
        chk($sformatf("v%0d out_be", i), 256'(out_byte_enable), 256'(vecs[i].eoseed));
        chk($sformatf("v%0d out_write", i), 256'(out_write), 256'(vecs[i].eow));
      end
    end

    // Wrap-around: two preloaded entries, then ten enqueue+dequeue cycles
    do_reset();
    sb.delete();
    for (int k = 0; k < 2; k++) begin
      a = 32'h300 + 32'(k) * 32'h20;
      cyc(1'b1, 1'b1, a, a ^ 32'h5A5A_0000, 1'b0, 32'h0);
      sb.push_back(a);
    end
    for (int k = 2; k < 12; k++) begin
      a = 32'h300 + 32'(k) * 32'h20;
      cyc(1'b1, 1'b1, a, a ^ 32'h5A5A_0000, 1'b1, 32'h0);
      void'(sb.pop_front());
      sb.push_back(a);
      chk($sformatf("wrap%0d count", k), 256'(count), 256'(2));
      chk($sformatf("wrap%0d out_address", k), 256'(out_address), 256'(sb[0]));
      chk($sformatf("wrap%0d out_wdata", k), out_wdata, {8{sb[0] ^ 32'h5A5A_0000}});
    end

    // Lookup priority: youngest matching write wins, reads never match
    do_reset();
    cyc(1'b1, 1'b1, 32'h200, 32'hA0A0_A0A0, 1'b0, 32'h204);
    chk("lk first write", lookup_wdata, {8{32'hA0A0_A0A0}});
    cyc(1'b1, 1'b0, 32'h200, 32'h1111_1111, 1'b0, 32'h204);
    chk("lk after read", lookup_wdata, {8{32'hA0A0_A0A0}});
    cyc(1'b1, 1'b1, 32'h21C, 32'hB0B0_B0B0, 1'b0, 32'h204);
    chk("lk youngest hit", 256'(lookup_hit), 256'(1));
    chk("lk youngest wdata", lookup_wdata, {8{32'hB0B0_B0B0}});
    chk("lk youngest be", 256'(lookup_byte_enable), 256'(32'hB0B0_B0B0));
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h204);
    chk("lk deq A wdata", lookup_wdata, {8{32'hB0B0_B0B0}});
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h204);
    chk("lk deq read hit", 256'(lookup_hit), 256'(1));
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h204);
    chk("lk drained hit", 256'(lookup_hit), 256'(0));
    chk("lk drained wdata", lookup_wdata, 256'(0));
    chk("lk drained be", 256'(lookup_byte_enable), 256'(0));
    chk("lk drained count", 256'(count), 256'(0));

    // Backpressure: head fields stay put while out_ready is low
    cyc(1'b1, 1'b1, 32'h400, 32'hC1C1_C1C1, 1'b0, 32'h400);
    cyc(1'b1, 1'b0, 32'h420, 32'hC2C2_C2C2, 1'b0, 32'h400);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h400);
      chk($sformatf("bp%0d out_valid", k), 256'(out_valid), 256'(1));
      chk($sformatf("bp%0d out_address", k), 256'(out_address), 256'(32'h400));
      chk($sformatf("bp%0d out_wdata", k), out_wdata, {8{32'hC1C1_C1C1}});
      chk($sformatf("bp%0d out_be", k), 256'(out_byte_enable), 256'(32'hC1C1_C1C1));
      chk($sformatf("bp%0d out_write", k), 256'(out_write), 256'(1));
    end

    // Asynchronous reset between edges with three entries queued
    cyc(1'b1, 1'b1, 32'h440, 32'hC3C3_C3C3, 1'b0, 32'h400);
    chk("mid count before", 256'(count), 256'(3));
    chk("mid hit before", 256'(lookup_hit), 256'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("mid count", 256'(count), 256'(0));
    chk("mid out_valid", 256'(out_valid), 256'(0));
    chk("mid in_ready", 256'(in_ready), 256'(1));
    chk("mid lookup_hit", 256'(lookup_hit), 256'(0));
    chk("mid out_address", 256'(out_address), 256'(0));
    // No enqueue while reset is held across an edge
    in_valid = 1'b1; in_write = 1'b1; in_address = 32'h480;
    @(posedge clk); #1;
    chk("rst held count", 256'(count), 256'(0));
    // First edge after release accepts an entry
    @(negedge clk);
    rst = 1'b1;
    in_address = 32'h500; in_wdata = {8{32'hD5D5_D5D5}}; in_byte_enable = 32'hD5D5_D5D5;
    @(posedge clk); #1;
    chk("post rst count", 256'(count), 256'(1));
    chk("post rst out_address", 256'(out_address), 256'(32'h500));
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
